// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-group push and decode-window pop bundle.
// Counts are packed from slot 0; slot 0 is the oldest entry.
interface fetch_queue_if #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4
);
  localparam int FCW = $clog2(FETCH_WIDTH + 1);
  localparam int DCW = $clog2(DECODE_WIDTH + 1);

  logic                          in_valid;
  logic [FCW-1:0]                in_count;
  logic [FETCH_WIDTH-1:0][31:0]  in_pc;
  logic [FETCH_WIDTH-1:0][31:0]  in_inst;
  logic [FETCH_WIDTH-1:0]        in_pred_taken;
  logic [FETCH_WIDTH-1:0][31:0]  in_pred_addr;
  logic                          in_ready;

  logic [DCW-1:0]                out_count;
  logic [DECODE_WIDTH-1:0][31:0] out_pc;
  logic [DECODE_WIDTH-1:0][31:0] out_inst;
  logic [DECODE_WIDTH-1:0]       out_pred_taken;
  logic [DECODE_WIDTH-1:0][31:0] out_pred_addr;
  logic [DCW-1:0]                out_accept;

  modport master (
    output in_valid, in_count, in_pc, in_inst,
    output in_pred_taken, in_pred_addr, out_accept,
    input  in_ready, out_count, out_pc, out_inst,
    input  out_pred_taken, out_pred_addr
  );

  modport slave (
    input  in_valid, in_count, in_pc, in_inst,
    input  in_pred_taken, in_pred_addr, out_accept,
    output in_ready, out_count, out_pc, out_inst,
    output out_pred_taken, out_pred_addr
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: ring buffer between fetch and decode with flush.
// FETCH_QUEUE_BYPASS_EN: empty queue forwards the incoming group.
module fetch_queue #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  fetch_queue_if.slave  bus,
  output logic [CW-1:0] occupancy
);
  localparam int PW  = $clog2(DEPTH);
  localparam int FCW = $clog2(FETCH_WIDTH + 1);
  localparam int DCW = $clog2(DECODE_WIDTH + 1);

  localparam logic [CW:0]    L_DEPTH = (CW+1)'(DEPTH);
  localparam logic [CW:0]    L_FW    = (CW+1)'(FETCH_WIDTH);
  localparam logic [FCW-1:0] L_FWC   = FCW'(FETCH_WIDTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] addr;
  } entry_t;

  entry_t         r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic [CW:0]    w_space;
  logic           w_in_ready;
  logic [FCW-1:0] w_push_n;
  logic [DCW-1:0] w_out_n;
  logic [DCW-1:0] w_pop_n;
  logic [DCW-1:0] w_skip;

  // Space is judged on the registered count only; pops are not credited.
  assign w_space    = L_DEPTH - {1'b0, r_count};
  assign w_in_ready = (w_space >= L_FW) && !flush && rst_n;

  always_comb begin
    w_push_n = '0;
    if (bus.in_valid && w_in_ready)
      w_push_n = (bus.in_count > L_FWC) ? L_FWC : bus.in_count;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_byp;
  assign w_byp = (r_count == '0) && (w_push_n != '0);
`endif

  always_comb begin
    w_out_n = '0;
    if (rst_n)
      w_out_n = (r_count >= CW'(DECODE_WIDTH)) ?
                DCW'(DECODE_WIDTH) : DCW'(r_count);
`ifdef FETCH_QUEUE_BYPASS_EN
    if (w_byp)
      w_out_n = (int'(w_push_n) >= DECODE_WIDTH) ?
                DCW'(DECODE_WIDTH) : DCW'(w_push_n);
`endif
  end

  always_comb begin
    w_pop_n = '0;
    if (!flush)
      w_pop_n = (bus.out_accept > w_out_n) ? w_out_n : bus.out_accept;
  end

  // Bypassed entries that decode takes this cycle are never stored.
  always_comb begin
    w_skip = '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (w_byp) w_skip = w_pop_n;
`endif
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_count = w_out_n;
  assign occupancy     = r_count;

  for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_out
    entry_t w_q;
    entry_t w_e;
    entry_t w_v;
    assign w_q = r_mem[r_rd_ptr + PW'(k)];
`ifdef FETCH_QUEUE_BYPASS_EN
    entry_t w_in_e;
    if (k < FETCH_WIDTH) begin : g_in
      assign w_in_e = '{bus.in_pc[k], bus.in_inst[k],
                        bus.in_pred_taken[k], bus.in_pred_addr[k]};
    end else begin : g_none
      assign w_in_e = '0;
    end
    assign w_e = w_byp ? w_in_e : w_q;
`else
    assign w_e = w_q;
`endif
    assign w_v = (DCW'(k) < w_out_n) ? w_e : '0;
    assign bus.out_pc[k]         = w_v.pc;
    assign bus.out_inst[k]       = w_v.inst;
    assign bus.out_pred_taken[k] = w_v.taken;
    assign bus.out_pred_addr[k]  = w_v.addr;
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (j >= int'(w_skip) && j < int'(w_push_n))
        r_mem[r_wr_ptr + PW'(j) - PW'(w_skip)] <=
          '{bus.in_pc[j], bus.in_inst[j],
            bus.in_pred_taken[j], bus.in_pred_addr[j]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push_n) - PW'(w_skip);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop_n) - PW'(w_skip);
      r_count  <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      a_in_count: assert (!bus.in_valid ||
                          int'(bus.in_count) <= FETCH_WIDTH);
      a_accept: assert (bus.out_accept <= w_out_n);
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised decoupling buffer between the fetch stage and decode.
- Accepts a fetch group of up to FETCH_WIDTH predicted instructions per cycle, each carrying pc, inst, predict_brunch_taken and predict_pc_addr.
- Presents up to DECODE_WIDTH oldest entries per cycle to decode.
- Replaces the fixed 4-wide, valid_number-style hand-off with a ring buffer of DEPTH entries, a count-based handshake and a flush for mispredict redirects.

Parameters:
- FETCH_WIDTH, 4: maximum entries pushed per cycle.
- DECODE_WIDTH, 4: maximum entries presented and popped per cycle.
- DEPTH, 16: ring capacity in entries. Must be a power of two, with DEPTH >= FETCH_WIDTH and DEPTH >= DECODE_WIDTH.
- CW, $clog2(DEPTH+1): width of the occupancy counter.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- flush, in, 1: discard all contents (redirect/mispredict).
- in_valid, in, 1: fetch group offered.
- in_count, in, $clog2(FETCH_WIDTH+1): number of valid slots in the group, packed from slot 0.
- in_pc, in, FETCH_WIDTH x 32: per-slot pc.
- in_inst, in, FETCH_WIDTH x 32: per-slot instruction.
- in_pred_taken, in, FETCH_WIDTH x 1: per-slot predicted taken.
- in_pred_addr, in, FETCH_WIDTH x 32: per-slot predicted target.
- in_ready, out, 1: queue can take a full group this cycle.
- out_count, out, $clog2(DECODE_WIDTH+1): number of valid output slots.
- out_pc, out, DECODE_WIDTH x 32: per-slot pc.
- out_inst, out, DECODE_WIDTH x 32: per-slot instruction.
- out_pred_taken, out, DECODE_WIDTH x 1: per-slot predicted taken.
- out_pred_addr, out, DECODE_WIDTH x 32: per-slot predicted target.
- out_accept, in, $clog2(DECODE_WIDTH+1): number of entries decode consumes this cycle, taken from slot 0.
- occupancy, out, CW: current entry count.

Behaviour:
- State:
  - wr_ptr and rd_ptr, log2(DEPTH) bits each; they wrap modulo DEPTH naturally.
  - count, CW bits.
  - entry storage, not reset.
- Reset: when rst_n is low at a posedge, wr_ptr, rd_ptr and count become 0. While rst_n is low, in_ready=0 and out_count=0.
- in_ready:
  - in_ready = (DEPTH - count >= FETCH_WIDTH) && !flush && rst_n.
  - It is computed from the registered count only. Same-cycle pops are not credited, to avoid a comb path from decode.
- Push:
  - Condition: push_n = (in_valid && in_ready) ? in_count : 0.
  - in_count > FETCH_WIDTH is illegal (assertion); in_count = 0 is a no-op.
  - Slot j (j < push_n) is written to index wr_ptr+j, and wr_ptr advances by push_n.
  - Program order is preserved: slot 0 is the oldest.
- Output:
  - out_count = min(count, DECODE_WIDTH).
  - Slot k (k < out_count) shows the entry at index rd_ptr+k.
  - Slots with k >= out_count drive all-zero fields.
  - Outputs are a combinational read of registered state, so push-to-visible latency is 1 cycle.
- Pop:
  - pop_n = min(out_accept, out_count). Over-accept is clipped and flagged by an assertion.
  - rd_ptr advances by pop_n.
- Simultaneous push and pop: count_next = count + push_n - pop_n, all in the same edge. Push and pop never collide, because push space is checked against the pre-pop count.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: wr_ptr = rd_ptr = count = 0.
  - During the flush cycle, in_ready=0. out_count still reflects the old contents, but any accept in that cycle is ignored.
- Full and empty:
  - count == DEPTH: out_count = DECODE_WIDTH and in_ready = 0.
  - count == 0: out_count = 0.
- Reset mid-operation: behaves identically to flush plus forced in_ready=0. No partial group survives.
- occupancy = count.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0, !flush and a push occurs, the output slots show the incoming group in the same cycle: out_count = min(push_n, DECODE_WIDTH), and slot k = in slot k.
  - pop_n of these entries is consumed directly. Only the remaining push_n - pop_n entries are written, starting at wr_ptr.
  - Pointers and count update accordingly.
  - This gives 0-cycle latency through an empty queue, at the cost of a comb path from in_* to out_*.
- Undefined: an empty queue always gives out_count=0, and the latency is 1 cycle.

Test Plan:
- Reset, then one cycle of idle → out_count=0, in_ready=1, occupancy=0. Assert rst_n=0 with in_valid=1, in_count=4 → no push, and occupancy stays 0.
- Push in_count=3 with pcs 0x100/0x104/0x108, out_accept=0 → next cycle out_count=3, out_pc[0..2] = 0x100/0x104/0x108, out_pc[3]=0, occupancy=3.
- Fill with 4 groups of 4 while out_accept=0 → occupancy=16, in_ready=0. A fifth in_valid is ignored. Then out_accept=4 for 4 cycles → entries drain in program order and pointers wrap.
- Steady state: push 4 and accept 2 per cycle from empty → occupancy 4, 6, 8, 10, 12; in_ready drops when occupancy reaches 13 or more. Order check via a scoreboard.
- With occupancy=9, assert flush together with in_valid=1 and out_accept=4 → next cycle occupancy=0 and out_count=0. Subsequent push in_count=2 with pc 0x2000 → out_pc[0]=0x2000 one cycle later.
- With BYPASS_EN defined and the queue empty, push in_count=4 (pc 0x40 onward) with out_accept=3 → same cycle out_count=4 and out_pc[0]=0x40. Next cycle occupancy=1 and out_pc[0]=0x4C.
